// File: rtl/boundary_strip_if.sv
// ============================================================================
// Module      : boundary_strip_if
// Description : Pixel stream bundle for boundary_strip (padded in, interior out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface boundary_strip_if #(
    parameter int dataWidth = 24
);
    logic                 iValid;
    logic [dataWidth-1:0] iData;
    logic                 oValid;
    logic [dataWidth-1:0] oData;
    logic                 oSof;
    logic                 oEol;
    logic                 oEof;
    logic [15:0]          oXCnt;
    logic [15:0]          oYCnt;
    logic                 oDone;
    logic                 oPadErr;

    modport master (
        output iValid, iData,
        input  oValid, oData, oSof, oEol, oEof, oXCnt, oYCnt, oDone, oPadErr
    );

    modport slave (
        input  iValid, iData,
        output oValid, oData, oSof, oEol, oEof, oXCnt, oYCnt, oDone, oPadErr
    );
endinterface

`default_nettype wire

// File: rtl/boundary_strip.sv
// ============================================================================
// Module      : boundary_strip
// Description : Strips the zero-padding ring from a padded raster stream and
//               tags interior pixels with markers and coordinates.
//               Optional pad-content check: BOUNDARY_STRIP_PADCHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boundary_strip #(
    parameter int width      = 320,
    parameter int height     = 240,
    parameter int kernelSize = 7,
    parameter int dataWidth  = 24
) (
    input  wire logic        clk,
    input  wire logic        reset,
    boundary_strip_if.slave  bus
);
    localparam int B  = (kernelSize - 1) / 2;
    localparam int WP = width + 2 * B;
    localparam int HP = height + 2 * B;

    localparam logic [15:0] cB       = 16'(B);
    localparam logic [15:0] cLastX   = 16'(WP - 1);
    localparam logic [15:0] cLastY   = 16'(HP - 1);
    localparam logic [15:0] cTopEnd  = 16'(B - 1);
    localparam logic [15:0] cBodyEnd = 16'(B + height - 1);
    localparam logic [15:0] cXEnd    = 16'(B + width);
    localparam logic [15:0] cEolX    = 16'(B + width - 1);

    typedef enum logic [1:0] {
        TOP    = 2'd0,
        BODY   = 2'd1,
        BOTTOM = 2'd2
    } stateType;

    // Without padding there is nothing to strip, so the FSM never leaves BODY.
    localparam stateType cResetState = (B == 0) ? BODY : TOP;

    stateType             rState;
    stateType             wStateNext;
    logic [15:0]          rInX;
    logic [15:0]          rInY;
    logic                 wLastX;
    logic                 wLastY;
    logic                 wXLow;
    logic                 wKeep;

    logic                 rValid;
    logic [dataWidth-1:0] rData;
    logic                 rSof;
    logic                 rEol;
    logic                 rEof;
    logic [15:0]          rXCnt;
    logic [15:0]          rYCnt;
    logic                 rDone;

    assign wLastX = (rInX == cLastX);
    assign wLastY = (rInY == cLastY);

    generate
        if (B == 0) begin : g_noPad
            assign wXLow = 1'b1;
        end else begin : g_pad
            assign wXLow = (rInX >= cB);
        end
    endgenerate

    assign wKeep = (rState == BODY) && wXLow && (rInX < cXEnd);

    always_ff @(posedge clk) begin
        if (reset) begin
            rInX <= 16'd0;
            rInY <= 16'd0;
        end else if (bus.iValid) begin
            if (wLastX) begin
                rInX <= 16'd0;
                rInY <= wLastY ? 16'd0 : rInY + 16'd1;
            end else begin
                rInX <= rInX + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rState <= cResetState;
        end else begin
            rState <= wStateNext;
        end
    end

    always_comb begin
        wStateNext = rState;
        if (bus.iValid && wLastX) begin
            case (rState)
                TOP:     if (rInY == cTopEnd)  wStateNext = BODY;
                BODY:    if (rInY == cBodyEnd) wStateNext = (B == 0) ? BODY : BOTTOM;
                BOTTOM:  if (wLastY)           wStateNext = TOP;
                default: wStateNext = cResetState;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rValid <= 1'b0;
            rData  <= '0;
            rSof   <= 1'b0;
            rEol   <= 1'b0;
            rEof   <= 1'b0;
            rXCnt  <= 16'd0;
            rYCnt  <= 16'd0;
            rDone  <= 1'b0;
        end else begin
            rDone  <= bus.iValid && wLastX && wLastY;
            rValid <= bus.iValid && wKeep;
            if (bus.iValid && wKeep) begin
                rData <= bus.iData;
                rXCnt <= rInX - cB;
                rYCnt <= rInY - cB;
                rSof  <= (rInX == cB) && (rInY == cB);
                rEol  <= (rInX == cEolX);
                rEof  <= (rInX == cEolX) && (rInY == cBodyEnd);
            end else begin
                rSof  <= 1'b0;
                rEol  <= 1'b0;
                rEof  <= 1'b0;
            end
        end
    end

`ifdef BOUNDARY_STRIP_PADCHECK_EN
    logic rPadErr;

    // Sticky: any non-zero discarded pixel flags the upstream padder as faulty.
    always_ff @(posedge clk) begin
        if (reset) begin
            rPadErr <= 1'b0;
        end else if (bus.iValid && !wKeep && (bus.iData != '0)) begin
            rPadErr <= 1'b1;
        end
    end

    assign bus.oPadErr = rPadErr;
`else
    assign bus.oPadErr = 1'b0;
`endif

    assign bus.oValid = rValid;
    assign bus.oData  = rData;
    assign bus.oSof   = rSof;
    assign bus.oEol   = rEol;
    assign bus.oEof   = rEof;
    assign bus.oXCnt  = rXCnt;
    assign bus.oYCnt  = rYCnt;
    assign bus.oDone  = rDone;

endmodule

`default_nettype wire

// File: tb/tb_boundary_strip.sv
// ============================================================================
// Module      : tb_boundary_strip
// Description : Directed, table-driven bench for boundary_strip (8x4, k=3 and 4x2, k=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boundary_strip;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    boundary_strip_if #(.dataWidth(24)) bus ();
    boundary_strip_if #(.dataWidth(24)) bus6 ();

    boundary_strip #(.width(8), .height(4), .kernelSize(3), .dataWidth(24)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    boundary_strip #(.width(4), .height(2), .kernelSize(1), .dataWidth(24)) dut6 (
        .clk(clk), .reset(reset), .bus(bus6)
    );

    typedef struct {
        logic        v;
        logic [23:0] d;
        logic        ev;
        logic [23:0] ed;
        logic [15:0] ex;
        logic [15:0] ey;
        logic        es;
        logic        el;
        logic        ee;
        logic        edn;
        logic        eerr;
    } vecT;

    vecT         vecs [60];
    vecT         gap;
    int          nErr = 0;
    int          nChk = 0;
    int          nOut = 0;
    int          cyc  = 0;
    int          lastDoneCyc = 0;
    int          lastSofCyc  = 0;
    int          firstDone   = 0;
    logic [23:0] holdData;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Padded 10x6 frame: interior pixel (x,y) carries y*16+x.
    task automatic buildFrame(input bit padTest);
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 10; x++) begin
                int i        = y * 10 + x;
                bit interior = (x >= 1) && (x <= 8) && (y >= 1) && (y <= 4);
                vecs[i].v    = 1'b1;
                if (padTest && !interior)
                    vecs[i].d = (x == 9 && y == 2) ? 24'h000001 : 24'h000000;
                else
                    vecs[i].d = 24'(y * 16 + x);
                vecs[i].ev   = interior;
                vecs[i].ed   = interior ? 24'(y * 16 + x) : 24'h0;
                vecs[i].ex   = interior ? 16'(x - 1) : 16'h0;
                vecs[i].ey   = interior ? 16'(y - 1) : 16'h0;
                vecs[i].es   = (x == 1) && (y == 1);
                vecs[i].el   = interior && (x == 8);
                vecs[i].ee   = (x == 8) && (y == 4);
                vecs[i].edn  = (x == 9) && (y == 5);
`ifdef BOUNDARY_STRIP_PADCHECK_EN
                vecs[i].eerr = padTest && (i >= 29);
`else
                vecs[i].eerr = 1'b0;
`endif
            end
        end
    endtask

    task automatic applyVec(input vecT t, input bit chkErr);
        bus.iValid = t.v;
        bus.iData  = t.d;
        @(posedge clk);
        #1;
        cyc++;
        chk("oValid", 32'(bus.oValid), 32'(t.ev));
        chk("oDone",  32'(bus.oDone),  32'(t.edn));
        chk("oSof",   32'(bus.oSof),   32'(t.es));
        chk("oEol",   32'(bus.oEol),   32'(t.el));
        chk("oEof",   32'(bus.oEof),   32'(t.ee));
        if (t.ev) begin
            chk("oData",  32'(bus.oData), 32'(t.ed));
            chk("oXCnt",  32'(bus.oXCnt), 32'(t.ex));
            chk("oYCnt",  32'(bus.oYCnt), 32'(t.ey));
            holdData = t.ed;
        end else begin
            chk("oDataHold", 32'(bus.oData), 32'(holdData));
        end
        if (chkErr)
            chk("oPadErr", 32'(bus.oPadErr), 32'(t.eerr));
        if (bus.oValid) nOut++;
        if (bus.oDone)  lastDoneCyc = cyc;
        if (bus.oSof)   lastSofCyc  = cyc;
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, ".oValid"},  32'(bus.oValid),  32'd0);
        chk({tag, ".oData"},   32'(bus.oData),   32'd0);
        chk({tag, ".oSof"},    32'(bus.oSof),    32'd0);
        chk({tag, ".oEol"},    32'(bus.oEol),    32'd0);
        chk({tag, ".oEof"},    32'(bus.oEof),    32'd0);
        chk({tag, ".oXCnt"},   32'(bus.oXCnt),   32'd0);
        chk({tag, ".oYCnt"},   32'(bus.oYCnt),   32'd0);
        chk({tag, ".oDone"},   32'(bus.oDone),   32'd0);
        chk({tag, ".oPadErr"}, 32'(bus.oPadErr), 32'd0);
        chk({tag, ".k1Valid"}, 32'(bus6.oValid), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        bus.iValid  = 1'b0;
        bus.iData   = 24'h0;
        bus6.iValid = 1'b0;
        bus6.iData  = 24'h0;
        holdData    = 24'h0;
        gap         = '{default: '0};
        gap.d       = 24'hABCDEF;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        // Continuous frame
        buildFrame(1'b0);
        nOut = 0;
        for (int i = 0; i < 60; i++) applyVec(vecs[i], 1'b0);
        chk("t1Count", nOut, 32);
        chk("t1FirstData", 32'(vecs[11].ed), 32'h11);

        // Same frame with an idle cycle after every pixel
        nOut = 0;
        for (int i = 0; i < 60; i++) begin
            applyVec(vecs[i], 1'b0);
            applyVec(gap, 1'b0);
        end
        chk("t2Count", nOut, 32);

        // Two back-to-back frames
        nOut = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 60; i++) applyVec(vecs[i], 1'b0);
            if (f == 0) firstDone = lastDoneCyc;
        end
        chk("t3Count", nOut, 64);
        chk("t3SofAfterDone", lastSofCyc - firstDone, 12);

        // Reset after 25 accepted pixels, with iValid high during reset
        for (int i = 0; i < 25; i++) applyVec(vecs[i], 1'b0);
        reset      = 1'b1;
        bus.iValid = 1'b1;
        bus.iData  = 24'h123456;
        @(posedge clk);
        #1;
        cyc++;
        checkAllZero("t4Reset");
        reset    = 1'b0;
        holdData = 24'h0;
        nOut     = 0;
        for (int i = 0; i < 60; i++) applyVec(vecs[i], 1'b0);
        chk("t4Count", nOut, 32);

        // Pad-content check: single non-zero pad at (9,2)
        bus.iValid = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        reset    = 1'b0;
        holdData = 24'h0;
        chk("t5PadErrReset", 32'(bus.oPadErr), 32'd0);
        buildFrame(1'b1);
        nOut = 0;
        for (int i = 0; i < 60; i++) applyVec(vecs[i], 1'b1);
        chk("t5Count", nOut, 32);
        gap.eerr = vecs[59].eerr;
        applyVec(gap, 1'b1);

        // kernelSize=1: every pixel forwarded
        for (int i = 0; i < 8; i++) begin
            bus6.iValid = 1'b1;
            bus6.iData  = 24'(256 + i);
            @(posedge clk);
            #1;
            cyc++;
            chk("k1Valid", 32'(bus6.oValid), 32'd1);
            chk("k1Data",  32'(bus6.oData),  32'(256 + i));
            chk("k1XCnt",  32'(bus6.oXCnt),  32'(i % 4));
            chk("k1YCnt",  32'(bus6.oYCnt),  32'(i / 4));
            chk("k1Sof",   32'(bus6.oSof),   32'(i == 0));
            chk("k1Eol",   32'(bus6.oEol),   32'((i % 4) == 3));
            chk("k1Eof",   32'(bus6.oEof),   32'(i == 7));
            chk("k1Done",  32'(bus6.oDone),  32'(i == 7));
        end
        bus6.iValid = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        chk("k1IdleValid", 32'(bus6.oValid), 32'd0);
        chk("k1IdleDone",  32'(bus6.oDone),  32'd0);
        chk("k1IdleHold",  32'(bus6.oData),  32'd263);

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/boundary_strip.md
# boundary_strip

Removes the zero-padding boundary ring that the filter input stage wraps around each demosaiced frame. It accepts the padded raster stream of (width+kernelSize-1) × (height+kernelSize-1) pixels and forwards only the interior width × height pixels, tagging each with frame and line markers and raster coordinates. It sits at the filter/colour-space side of the pipeline, wherever a padded-geometry stream must be turned back into a clean frame for the matrix multipliers, the frame buffer or the display.

## Interface
Parameters:
- width, 320, interior pixels per row
- height, 240, interior rows per frame
- kernelSize, 7, odd; padding per side B = (kernelSize-1)/2
- dataWidth, 24, pixel width ({R,G,B} packed 8/8/8)

Derived values: W' = width+2B and H' = height+2B.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- iValid  in  1  input pixel qualifier; no backpressure
- iData  in  dataWidth  padded-stream pixel
- oValid  out  1  interior pixel valid
- oData  out  dataWidth  interior pixel
- oSof  out  1  first interior pixel of frame (x=0,y=0)
- oEol  out  1  last pixel of an interior row (x=width-1)
- oEof  out  1  last interior pixel of frame
- oXCnt  out  16  interior column of oData
- oYCnt  out  16  interior row of oData
- oDone  out  1  one-cycle pulse after the last padded pixel of the frame is accepted
- oPadErr  out  1  sticky pad-content error (see Configuration)

## Operation
- Input counters inX (0..W'-1) and inY (0..H'-1) advance only on iValid. inX wraps at W'-1 and then increments inY. inY wraps at H'-1, returning both counters to 0.
- FSM states:
  - TOP: inY < B.
  - BODY: B ≤ inY < B+height.
  - BOTTOM: inY ≥ B+height.
- FSM transitions, all taken on the accepted pixel with inX=W'-1:
  - TOP → BODY when inY=B-1.
  - BODY → BOTTOM when inY=B+height-1.
  - BOTTOM → TOP when inY=H'-1.
- When B=0 (kernelSize=1), the FSM lives permanently in BODY and nothing is stripped.
- Keep rule: a pixel is forwarded iff the state is BODY and B ≤ inX < B+width. All other accepted pixels are discarded.
- Coordinates: oXCnt = inX-B and oYCnt = inY-B, both registered with oData.
- Markers:
  - oSof when the output coordinates are (0,0).
  - oEol when oXCnt=width-1.
  - oEof when oEol is set and oYCnt=height-1.
  - All markers are qualified by oValid.
- oDone is asserted for 1 cycle following acceptance of pixel (W'-1, H'-1). The FSM is already in TOP in that cycle, so the next frame may start immediately, back-to-back with no gap.
- Gaps in iValid: counters, state and the oPadErr accumulator hold their values; oValid=0 during the gap.

## Timing
- Latency: 1 cycle from iValid/iData to oValid/oData. All outputs are registered.
- oData/oXCnt/oYCnt hold their last values when oValid=0. Markers are 0 whenever oValid=0.
- Reset values: oValid=0, oData=0, oSof=oEol=oEof=0, oXCnt=oYCnt=0, oDone=0, oPadErr=0; inX=inY=0; state TOP (BODY if B=0).
- Reset mid-frame: the partial frame is abandoned with no oDone. The next accepted pixel is treated as (0,0) of a new padded frame.
- Throughput: 1 pixel/cycle sustained. Output rate over one frame is width·height / (W'·H') of the input rate.
- Simultaneous events:
  - reset wins over iValid.
  - On the last pixel of a frame, the state change, counter wrap and oDone scheduling all occur in the same cycle.

## Configuration
- Macro: BOUNDARY_STRIP_PADCHECK_EN.
- Defined: each discarded pixel with iData ≠ 0 sets oPadErr one cycle later. oPadErr stays at 1 until reset and does not block forwarding.
- Undefined: the check logic is absent and oPadErr is tied to 0.

## Test plan
All scenarios use width=8, height=4, kernelSize=3, giving B=1, W'=10, H'=6, 60 input pixels per frame.

1. Continuous iValid; iData = inY·16+inX for every pixel.
   - Exactly 32 oValid pulses.
   - First output: oData=0x11, oSof=1, (0,0).
   - Each row ends with oEol; the row-3 end gives oData=0x48 and oEof=1.
   - oDone fires once, 1 cycle after input #60.
2. Same stimulus, with iValid deasserted every other cycle.
   - Identical output sequence and coordinates.
   - No oValid during gaps; oDone fires after the 60th accepted pixel.
3. Two frames back-to-back, no idle cycle.
   - Second frame's oSof occurs 12 cycles after the first frame's oDone, on accepted input #12 of frame 2.
   - 64 outputs in total.
4. Assert reset for 1 cycle after 25 accepted pixels, then send a full frame.
   - All outputs are 0 during reset.
   - No oDone for the aborted frame.
   - The following frame produces 32 outputs starting with oSof.
5. Macro defined; frame with all pads zero except pad pixel (inX=9, inY=2) = 0x000001.
   - oPadErr=0 until 1 cycle after that pixel is accepted, then stays 1.
   - All 32 outputs are still correct.
   - Macro undefined: oPadErr stays 0.
6. kernelSize=1, width=4, height=2.
   - All 8 inputs are forwarded with 1-cycle latency.
   - oSof on the first pixel, oEol on pixels 4 and 8, oEof on pixel 8.
   - oDone fires 1 cycle after pixel 8.
